// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the cosim deadlock detector (report arbiter and detect units).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: report-arbiter state enum, fixed-priority one-hot pick, one-hot to binary index.
package aesl_deadlock_pkg;

  // Upper bound on the number of detect units the helpers below can handle.
  localparam int DL_VEC_MAX   = 32;
  localparam int DL_IDX_MAX_W = 5;

  typedef enum logic [2:0] {
    DL_IDLE   = 3'd0,
    DL_CHECK  = 3'd1,
    DL_CLEAR  = 3'd2,
    DL_REPORT = 3'd3,
    DL_LOCKED = 3'd4
  } dl_rpt_state_t;

  // Isolate the lowest set bit: two's-complement trick, x & -x.
  function automatic logic [DL_VEC_MAX-1:0] lowest_onehot(input logic [DL_VEC_MAX-1:0] vec);
    return vec & (~vec + DL_VEC_MAX'(1));
  endfunction

  // Binary index of a one-hot vector (OR-reduction form, no priority chain).
  function automatic logic [DL_IDX_MAX_W-1:0] onehot2idx(input logic [DL_VEC_MAX-1:0] vec);
    logic [DL_IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DL_VEC_MAX; i++) begin
      if (vec[i]) idx = idx | DL_IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/aesl_prio_onehot.sv
// Fixed-priority one-hot picker: grants the lowest-index asserted request.
// Latency: combinational.
// Backpressure: none; pure function of req.
// Ports: req [WIDTH] request vector in, gnt [WIDTH] one-hot (or zero) grant out. WIDTH <= 32.
module aesl_prio_onehot
  import aesl_deadlock_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  assign gnt = WIDTH'(lowest_onehot(DL_VEC_MAX'(req)));

endmodule

// File: rtl/aesl_deadlock_report_arbiter.sv
// Elects one origin among the detect units, freezes them, confirms the deadlock persists, then reports and locks.
// Latency: dl_in_vec rise -> dl_detect_out/origin next cycle; earliest dl_report_vld CONFIRM_CYCLES cycles after that.
// Backpressure: none; dl_in_vec is sampled every cycle, all outputs are registered.
// Ports: clock, reset (async active-low); dl_in_vec [PROC_NUM] per-unit flags in;
//        dl_detect_out freeze broadcast; origin [PROC_NUM] one-hot elected unit; token_clear abort pulse;
//        dl_report_vld/dl_report_idx confirmed report; dl_locked sticky; false_alarm_cnt [16] saturating aborts.
module aesl_deadlock_report_arbiter
  import aesl_deadlock_pkg::*;
#(
  parameter int PROC_NUM       = 3,
  parameter int CONFIRM_CYCLES = 4,
  parameter int IDX_W          = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_report_vld,
  output logic [IDX_W-1:0]    dl_report_idx,
  output logic                dl_locked,
  output logic [15:0]         false_alarm_cnt
);

  localparam int             CNT_W    = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);

  dl_rpt_state_t      state;
  logic [CNT_W-1:0]   cnt;
  logic [PROC_NUM-1:0] pick;
  logic               origin_hit;
  logic [IDX_W-1:0]   origin_idx;

  aesl_prio_onehot #(
    .WIDTH(PROC_NUM)
  ) u_pick (
    .req(dl_in_vec),
    .gnt(pick)
  );

  // Only the elected unit's flag matters while confirming; the others are frozen anyway.
  assign origin_hit = |(dl_in_vec & origin);
  assign origin_idx = IDX_W'(onehot2idx(DL_VEC_MAX'(origin)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= DL_IDLE;
      cnt             <= '0;
      dl_detect_out   <= 1'b0;
      origin          <= '0;
      token_clear     <= 1'b0;
      dl_report_vld   <= 1'b0;
      dl_report_idx   <= '0;
      dl_locked       <= 1'b0;
      false_alarm_cnt <= '0;
    end else begin
      // Single-cycle pulses default low; the arms below raise them on entry to CLEAR/REPORT.
      token_clear   <= 1'b0;
      dl_report_vld <= 1'b0;
      case (state)
        DL_IDLE: begin
          if (|dl_in_vec) begin
            state         <= DL_CHECK;
            origin        <= pick;
            dl_detect_out <= 1'b1;
            cnt           <= '0;
          end
        end
        DL_CHECK: begin
          if (origin_hit) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state         <= DL_REPORT;
              dl_report_vld <= 1'b1;
              dl_report_idx <= origin_idx;
            end
          end else begin
            // Origin let go before confirmation: abort, release the units and re-arm.
            state         <= DL_CLEAR;
            token_clear   <= 1'b1;
            dl_detect_out <= 1'b0;
            origin        <= '0;
            if (false_alarm_cnt != 16'hFFFF) false_alarm_cnt <= false_alarm_cnt + 16'd1;
          end
        end
        DL_CLEAR: begin
          // Units are dropping their tokens this cycle, so their flags are not trusted yet.
          state <= DL_IDLE;
        end
        DL_REPORT: begin
          state     <= DL_LOCKED;
          dl_locked <= 1'b1;
        end
        DL_LOCKED: begin
          // Terminal until reset; everything holds.
        end
        default: begin
          state         <= DL_IDLE;
          dl_detect_out <= 1'b0;
          origin        <= '0;
        end
      endcase
    end
  end

endmodule
